// File: rtl/mem_dbus_ctrl.sv
// MEM-stage load/store controller: drives a req/ack data bus with big-endian
// byte-lane steering, load extension, stall requests and MEM/WB write info.
module mem_dbus_ctrl #(
    parameter int                  N_ALU_OP       = 8,
    parameter int                  TIMEOUT_CYCLES = 255,
    parameter logic [N_ALU_OP-1:0] EXE_LB_OP      = 8'b1110_0000,
    parameter logic [N_ALU_OP-1:0] EXE_LH_OP      = 8'b1110_0001,
    parameter logic [N_ALU_OP-1:0] EXE_LW_OP      = 8'b1110_0011,
    parameter logic [N_ALU_OP-1:0] EXE_LBU_OP     = 8'b1110_0100,
    parameter logic [N_ALU_OP-1:0] EXE_LHU_OP     = 8'b1110_0101,
    parameter logic [N_ALU_OP-1:0] EXE_SB_OP      = 8'b1110_1000,
    parameter logic [N_ALU_OP-1:0] EXE_SH_OP      = 8'b1110_1001,
    parameter logic [N_ALU_OP-1:0] EXE_SW_OP      = 8'b1110_1011
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_ALU_OP-1:0] i_mem_aluop,
    input  logic [31:0]         i_mem_addr,
    input  logic [31:0]         i_mem_data,
    input  logic                i_mem_wen,
    input  logic [4:0]          i_mem_waddr,
    input  logic [31:0]         i_mem_wdata,
    input  logic                i_flush,
    input  logic                i_stall_wb,
    output logic                o_stallreq,
    output logic                o_dbus_req,
    output logic                o_dbus_we,
    output logic [31:0]         o_dbus_addr,
    output logic [3:0]          o_dbus_sel,
    output logic [31:0]         o_dbus_wdata,
    input  logic                i_dbus_ack,
    input  logic [31:0]         i_dbus_rdata,
    output logic                o_wb_wen,
    output logic [4:0]          o_wb_waddr,
    output logic [31:0]         o_wb_wdata,
    output logic                o_except_adel,
    output logic                o_except_ades,
    output logic                o_bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_req_t;

    state_t           state_q, state_d;
    bus_req_t         bus_q, bus_d;
    logic             req_q;
    logic [31:0]      rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic        is_load, is_store, is_mem, misalign;
    logic        busy, timeout, bus_done;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Opcode decode and alignment check
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        case (i_mem_aluop)
            EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; misalign = i_mem_addr[0];    end
            EXE_LW_OP:             begin is_load  = 1'b1; misalign = |i_mem_addr[1:0]; end
            EXE_SB_OP:             is_store = 1'b1;
            EXE_SH_OP:             begin is_store = 1'b1; misalign = i_mem_addr[0];    end
            EXE_SW_OP:             begin is_store = 1'b1; misalign = |i_mem_addr[1:0]; end
            default: ;
        endcase
    end

    assign is_mem        = is_load | is_store;
    assign o_except_adel = is_load & misalign;
    assign o_except_ades = is_store & misalign;

    // Store lane steering; big-endian, so byte 0 lives in bits [31:24]
    always_comb begin
        bus_d.we    = is_store;
        bus_d.addr  = {i_mem_addr[31:2], 2'b00};
        bus_d.sel   = 4'b1111;
        bus_d.wdata = 32'h0;
        case (i_mem_aluop)
            EXE_SB_OP: begin
                bus_d.sel   = 4'b1000 >> i_mem_addr[1:0];
                bus_d.wdata = {4{i_mem_data[7:0]}};
            end
            EXE_SH_OP: begin
                bus_d.sel   = i_mem_addr[1] ? 4'b0011 : 4'b1100;
                bus_d.wdata = {2{i_mem_data[15:0]}};
            end
            EXE_SW_OP: bus_d.wdata = i_mem_data;
            default: ;
        endcase
    end

    // Load extraction works from the latched word; EX/MEM holds addr/op meanwhile
    always_comb begin
        case (i_mem_addr[1:0])
            2'd0:    ld_byte = rd_q[31:24];
            2'd1:    ld_byte = rd_q[23:16];
            2'd2:    ld_byte = rd_q[15:8];
            default: ld_byte = rd_q[7:0];
        endcase
        ld_half = i_mem_addr[1] ? rd_q[15:0] : rd_q[31:16];
        case (i_mem_aluop)
            EXE_LB_OP:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ld_ext = {24'h0, ld_byte};
            EXE_LH_OP:  ld_ext = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ld_ext = {16'h0, ld_half};
            default:    ld_ext = rd_q;
        endcase
    end

    assign busy     = (state_q == REQ) || (state_q == DRAIN);
    assign timeout  = (TIMEOUT_CYCLES != 0) && busy && !i_dbus_ack && (cnt_q == CNT_LAST);
    assign bus_done = busy && (i_dbus_ack || timeout);

    always_comb begin
        state_d    = state_q;
        o_stallreq = 1'b0;
        o_wb_wen   = i_mem_wen;
        o_wb_wdata = i_mem_wdata;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    o_wb_wen = 1'b0;
                    if (!misalign && !i_flush) begin
                        o_stallreq = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                o_stallreq = 1'b1;
                o_wb_wen   = 1'b0;
                if (bus_done)     state_d = i_flush ? IDLE : DONE;
                else if (i_flush) state_d = DRAIN;
            end
            DONE: begin
                o_wb_wen   = is_load & i_mem_wen;
                o_wb_wdata = is_load ? ld_ext : i_mem_wdata;
                if (i_flush || !i_stall_wb) state_d = IDLE;
            end
            DRAIN: begin
                // The bus cannot be cancelled; just wait it out and discard
                o_stallreq = is_mem;
                o_wb_wen   = 1'b0;
                if (bus_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) o_wb_wen = 1'b0;
    end

    assign o_wb_waddr = i_mem_waddr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bus_q   <= '0;
            req_q   <= 1'b0;
            rd_q    <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            if (state_q == IDLE && state_d == REQ) begin
                req_q <= 1'b1;
                bus_q <= bus_d;
            end else if (bus_done) begin
                req_q <= 1'b0;
            end
            if (state_q == REQ && i_dbus_ack)   rd_q <= i_dbus_rdata;
            else if (state_q == REQ && timeout) rd_q <= 32'h0;
            if (busy && !bus_done) cnt_q <= cnt_q + 1'b1;
            else                   cnt_q <= '0;
        end
    end

    assign o_dbus_req   = req_q;
    assign o_dbus_we    = bus_q.we;
    assign o_dbus_addr  = bus_q.addr;
    assign o_dbus_sel   = bus_q.sel;
    assign o_dbus_wdata = bus_q.wdata;
    assign o_bus_err    = err_q;

endmodule
